kernel_window_matcher: RTL and testbench

Sequencer and matcher on the read side of the kernel address generator. On `start` it walks `k_addr` over all M*M kernel positions, samples the returned kernel bit, and compares it against a latched binary pixel window. It produces one binary erosion or dilation result per window, with a one-cycle `done` pulse. It sits between the line-buffer/window former and the output pixel writer in the binary morphology path.

---
 rtl/kernel_window_matcher.sv | 136 +++++++++++++
 tb/tb_kernel_window_matcher.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/kernel_window_matcher.sv
// Scans all M*M kernel addresses once per latched binary window and reports the
// erosion/dilation result with the kernel population and hit counts.
module kernel_window_matcher #(
    parameter int M      = 3,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                mode,
    input  logic [M*M-1:0]      window,
    output logic [ADDR_W-1:0]   k_addr,
    input  logic                k_bit,
    output logic                busy,
    output logic                done,
    output logic                result,
    output logic [CNT_W-1:0]    ones_count,
    output logic [CNT_W-1:0]    hit_count
);

    localparam int N     = M * M;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               load_s;
    logic               last_s;
    logic               win_bit_s;
    logic [CNT_W-1:0]   ones_s;
    logic [CNT_W-1:0]   hits_s;
    logic [N-1:0]       win_q;
    logic               mode_q;
    logic [CNT_W-1:0]   ones_r;
    logic [CNT_W-1:0]   hits_r;

    assign last_s    = (k_addr == LAST_ADDR);
    assign win_bit_s = win_q[k_addr[IDX_W-1:0]];
    assign ones_s    = ones_r + {{(CNT_W-1){1'b0}}, k_bit};
    assign hits_s    = hits_r + {{(CNT_W-1){1'b0}}, k_bit & win_bit_s};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the DONE exit edge also samples start so windows
    // can stream back to back every M*M+1 cycles.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SCAN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Address walk, accumulation and registered result outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_addr     <= {ADDR_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 1'b0;
            ones_count <= {CNT_W{1'b0}};
            hit_count  <= {CNT_W{1'b0}};
            win_q      <= {N{1'b0}};
            mode_q     <= 1'b0;
            ones_r     <= {CNT_W{1'b0}};
            hits_r     <= {CNT_W{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    k_addr <= {ADDR_W{1'b0}};
                    if (load_s) begin
                        win_q  <= window;
                        mode_q <= mode;
                        ones_r <= {CNT_W{1'b0}};
                        hits_r <= {CNT_W{1'b0}};
                        busy   <= 1'b1;
                    end else begin
                        busy   <= 1'b0;
                    end
                end
                SCAN: begin
                    ones_r <= ones_s;
                    hits_r <= hits_s;
                    if (last_s) begin
                        k_addr     <= {ADDR_W{1'b0}};
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        ones_count <= ones_s;
                        hit_count  <= hits_s;
                        // Erosion: every set kernel bit hit; dilation: any hit.
                        result     <= mode_q ? (hits_s != {CNT_W{1'b0}}) : (hits_s == ones_s);
                    end else begin
                        k_addr <= k_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    k_addr <= {ADDR_W{1'b0}};
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_window_matcher.sv
// Directed and randomized bench for kernel_window_matcher; expected values come
// from population counts of kernel and kernel&window.
module tb_kernel_window_matcher;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        mode;
    logic [8:0]  window;
    logic [6:0]  k_addr;
    logic        k_bit;
    logic        busy;
    logic        done;
    logic        result;
    logic [3:0]  ones_count;
    logic [3:0]  hit_count;
    logic [8:0]  kernel;

    int tests = 0;
    int fails = 0;

    kernel_window_matcher #(.M(3), .ADDR_W(7), .CNT_W(4)) dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .window(window),
        .k_addr(k_addr), .k_bit(k_bit), .busy(busy), .done(done),
        .result(result), .ones_count(ones_count), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    // Kernel memory: combinational read, zero outside the valid range.
    assign k_bit = (k_addr < 7'd9) ? kernel[k_addr[3:0]] : 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_result(input logic [8:0] kern, input logic [8:0] win, input logic m);
        logic [3:0] e_ones;
        logic [3:0] e_hits;
        logic       e_res;
        e_ones = 4'($countones(kern));
        e_hits = 4'($countones(kern & win));
        e_res  = m ? (e_hits != 4'd0) : (e_hits == e_ones);
        check("ones_count", 32'(ones_count), 32'(e_ones));
        check("hit_count", 32'(hit_count), 32'(e_hits));
        check("result", 32'(result), 32'(e_res));
    endtask

    // One window; restart_edge > 0 re-pulses start so that it is sampled at that edge.
    task automatic run(input logic [8:0] kern, input logic [8:0] win, input logic m,
                       input int restart_edge);
        int cycles;
        @(negedge clk);
        kernel = kern; window = win; mode = m; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        window = 9'($urandom); mode = ~m; start = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            check("k_addr_seq", 32'(k_addr), 32'(cycles));
            check("busy_scan", 32'(busy), 32'd1);
            @(negedge clk);
            cycles++;
            start = (cycles == restart_edge - 1);
        end
        check("done_latency", 32'(cycles), 32'd9);
        check("k_addr_done", 32'(k_addr), 32'd0);
        check("busy_done", 32'(busy), 32'd0);
        expect_result(kern, win, m);
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        logic [8:0] k;
        logic [8:0] w [3];
        logic       m;

        rstn = 1'b0; start = 1'b0; mode = 1'b0; window = 9'd0; kernel = 9'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_k_addr", 32'(k_addr), 32'd0);
        check("rst_ones", 32'(ones_count), 32'd0);
        check("rst_hits", 32'(hit_count), 32'd0);
        rstn = 1'b1;

        // Directed cases from the test plan.
        run(9'b010111010, 9'b111111111, 1'b0, 0);
        check("full_match_ones", 32'(ones_count), 32'd5);
        check("full_match_res", 32'(result), 32'd1);
        run(9'b010111010, 9'b010101010, 1'b0, 0);
        check("miss_hits", 32'(hit_count), 32'd4);
        check("miss_res", 32'(result), 32'd0);
        run(9'b010111010, 9'b010101010, 1'b1, 0);
        check("miss_dil_res", 32'(result), 32'd1);
        run(9'b000000000, 9'b101100111, 1'b0, 0);
        check("empty_ero_res", 32'(result), 32'd1);
        run(9'b000000000, 9'b101100111, 1'b1, 0);
        check("empty_dil_res", 32'(result), 32'd0);
        check("empty_ones", 32'(ones_count), 32'd0);
        run(9'b000010000, 9'b111101111, 1'b1, 0);
        check("no_overlap_hits", 32'(hit_count), 32'd0);
        check("no_overlap_res", 32'(result), 32'd0);

        // Start re-pulsed at T4 is ignored: one done only.
        run(9'b110011001, 9'b100011101, 1'b0, 4);
        for (int i = 0; i < 12; i++) begin
            check("no_extra_done", 32'(done), 32'd0);
            @(negedge clk);
        end

        // Start held high: a done every 10 cycles, each for the window latched at its start.
        k = 9'($urandom); m = 1'($urandom);
        for (int i = 0; i < 3; i++) w[i] = 9'($urandom);
        @(negedge clk);
        kernel = k; window = w[0]; mode = m; start = 1'b1;
        @(posedge clk);
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            check("b2b_done", 32'(done), 32'((t % 10) == 9));
            if ((t % 10) == 9) expect_result(k, w[t / 10], m);
            if (t == 0)  window = w[1];
            if (t == 10) window = w[2];
            if (t == 29) start = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset during SCAN aborts immediately without a done pulse.
        @(negedge clk);
        kernel = 9'b111111111; window = 9'b111111111; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_k_addr", 32'(k_addr), 32'd0);
        check("abort_ones", 32'(ones_count), 32'd0);
        check("abort_hits", 32'(hit_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_abort_no_done", 32'(done), 32'd0);
        end
        run(9'b101010101, 9'b111010111, 1'b0, 0);

        // Randomized windows against the population-count model.
        for (int i = 0; i < 20; i++) begin
            run(9'($urandom), 9'($urandom), 1'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
